// File: rtl/pc_pkg.sv
// Shared widths, reset vector and address/byte types for the program counter stage.
package pc_pkg;
    localparam int PC_WIDTH   = 16;
    localparam int BYTE_WIDTH = 8;
    localparam int NIBBLE     = 4;

    typedef logic [PC_WIDTH-1:0]   pc_t;
    typedef logic [BYTE_WIDTH-1:0] byte_t;

    localparam pc_t RESET_VECTOR = 16'h0000;
endpackage

// File: rtl/pc_counter16_if.sv
// CPU-side bus of the program counter: byte bus, active-low load strobes, count enable and PC outputs.
// Handshake: no valid/ready; every control is sampled at the rising CP edge and outputs change only after it.
interface pc_counter16_if import pc_pkg::*; #(parameter int WIDTH = PC_WIDTH) ();
    logic [WIDTH/2-1:0] D;
    logic               _pchitmp_in;
    logic               _pclo_in;
    logic               _pc_in;
    logic               COND;
    logic               CNT_EN;
    logic [WIDTH-1:0]   PC;
    logic [WIDTH/2-1:0] PCHITMP;
    logic               TC;

    modport master (
        output D, _pchitmp_in, _pclo_in, _pc_in, COND, CNT_EN,
        input  PC, PCHITMP, TC
    );

    modport slave (
        input  D, _pchitmp_in, _pclo_in, _pc_in, COND, CNT_EN,
        output PC, PCHITMP, TC
    );
endinterface

// File: rtl/pc_nibble.sv
// 4-bit synchronous counter slice: parallel load (_PE) beats counting, which needs CEP and CET.
module pc_nibble import pc_pkg::*; #(
    parameter logic [NIBBLE-1:0] RST_VAL = '0
) (
    input  logic              CP,
    input  logic              _MR,
    input  logic              CEP,
    input  logic              CET,
    input  logic              _PE,
    input  logic [NIBBLE-1:0] D,
    output logic [NIBBLE-1:0] Q,
    output logic              TC
);
    logic [NIBBLE-1:0] q_q;
    logic [NIBBLE-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (!_PE) begin
            q_d = D;
        end else if (CEP && CET) begin
            q_d = q_q + 4'd1;
        end
    end

    always_ff @(posedge CP or negedge _MR) begin
        if (!_MR) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q  = q_q;
    assign TC = (&q_q) & CET;
endmodule

// File: rtl/pc_counter16.sv
// Program counter built from chained 4-bit slices; jumps load {PCHITMP, D}, otherwise counts or holds.
module pc_counter16 import pc_pkg::*; #(
    parameter int               WIDTH        = PC_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VECTOR = pc_pkg::RESET_VECTOR
) (
    input  logic         CP,
    input  logic         _MR,
    pc_counter16_if.slave bus
);
    localparam int NSLICE = WIDTH / NIBBLE;
    localparam int HALF   = WIDTH / 2;

    logic             load;
    logic [WIDTH-1:0] ld_val;
    logic [WIDTH-1:0] pc;
    logic [HALF-1:0]  pchitmp_q;
    logic [HALF-1:0]  pchitmp_d;

    assign load   = !bus._pclo_in || (!bus._pc_in && bus.COND);
    // The jump target uses the pre-edge PCHITMP even when it is being rewritten at the same edge.
    assign ld_val = {pchitmp_q, bus.D};

    always_comb begin
        pchitmp_d = pchitmp_q;
        if (!bus._pchitmp_in) begin
            pchitmp_d = bus.D;
        end
    end

    always_ff @(posedge CP or negedge _MR) begin
        if (!_MR) begin
            pchitmp_q <= '0;
        end else begin
            pchitmp_q <= pchitmp_d;
        end
    end

    for (genvar i = 0; i < NSLICE; i++) begin : g_slice
        logic cet;
        logic tc;
        if (i == 0) begin : g_first
            assign cet = bus.CNT_EN;
        end else begin : g_next
            assign cet = g_slice[i-1].tc;
        end

        pc_nibble #(
            .RST_VAL (RESET_VECTOR[i*NIBBLE +: NIBBLE])
        ) u_nibble (
            .CP  (CP),
            ._MR (_MR),
            .CEP (bus.CNT_EN),
            .CET (cet),
            ._PE (!load),
            .D   (ld_val[i*NIBBLE +: NIBBLE]),
            .Q   (pc[i*NIBBLE +: NIBBLE]),
            .TC  (tc)
        );
    end

    assign bus.PC      = pc;
    assign bus.PCHITMP = pchitmp_q;
    assign bus.TC      = g_slice[NSLICE-1].tc;
endmodule
